// File: rtl/line_raster.sv
`default_nettype none
// =============================================================================
// Module   : line_raster
// Purpose  : Bresenham line rasteriser emitting one pixel per handshake on a
//            back-pressured stream. Define LINE_RASTER_CLIP_EN for clipping.
// Revision : 1.0 - initial release
// =============================================================================
module line_raster #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int LEN_W    = 8,
    parameter int COLOR_W  = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [X_W-1:0]     cmd_x0,
    input  logic [Y_W-1:0]     cmd_y0,
    input  logic [LEN_W-1:0]   cmd_dx,
    input  logic [LEN_W-1:0]   cmd_dy,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [X_W-1:0]     pix_x,
    output logic [Y_W-1:0]     pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               busy,
    output logic               done
);

    localparam int XI_W  = X_W + 2;
    localparam int YI_W  = Y_W + 2;
    localparam int ERR_W = LEN_W + 3;
    localparam int E2_W  = LEN_W + 4;
    localparam int CNT_W = LEN_W + 1;

    if (SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_screen
        $error("line_raster: SCREEN_W and SCREEN_H must be positive");
    end

`ifdef LINE_RASTER_CLIP_EN
    localparam logic signed [XI_W-1:0] C_SCR_W = XI_W'(SCREEN_W);
    localparam logic signed [YI_W-1:0] C_SCR_H = YI_W'(SCREEN_H);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_DRAW  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [XI_W-1:0]   x_q, x_d;
    logic signed [YI_W-1:0]   y_q, y_d;
    logic [LEN_W-1:0]         dx_q, dx_d;
    logic [LEN_W-1:0]         dy_q, dy_d;
    logic [COLOR_W-1:0]       color_q, color_d;
    logic [LEN_W:0]           adx_q, adx_d;
    logic [LEN_W:0]           ady_q, ady_d;
    logic                     sx_neg_q, sx_neg_d;
    logic                     sy_neg_q, sy_neg_d;
    logic signed [ERR_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     pix_valid_q, pix_valid_d;
    logic [X_W-1:0]           pix_x_q, pix_x_d;
    logic [Y_W-1:0]           pix_y_q, pix_y_d;
    logic                     done_q, done_d;

    logic signed [LEN_W:0]    dx_ext, dy_ext;
    logic [LEN_W:0]           abs_dx, abs_dy;
    logic signed [E2_W-1:0]   e2, neg_ady, adx_s;
    logic signed [ERR_W-1:0]  err_step;
    logic signed [XI_W-1:0]   x_step;
    logic signed [YI_W-1:0]   y_step;
    logic                     step_x, step_y, offscreen, out_free;

    // Bresenham step terms for the pixel currently held by the iterator
    always_comb begin
        dx_ext   = {dx_q[LEN_W-1], dx_q};
        dy_ext   = {dy_q[LEN_W-1], dy_q};
        abs_dx   = dx_q[LEN_W-1] ? $unsigned(-dx_ext) : $unsigned(dx_ext);
        abs_dy   = dy_q[LEN_W-1] ? $unsigned(-dy_ext) : $unsigned(dy_ext);
        e2       = {err_q, 1'b0};
        neg_ady  = -$signed({3'b000, ady_q});
        adx_s    = $signed({3'b000, adx_q});
        step_x   = (e2 > neg_ady);
        step_y   = (e2 < adx_s);
        err_step = err_q;
        if (step_x) begin
            err_step = err_step - $signed({2'b00, ady_q});
        end
        if (step_y) begin
            err_step = err_step + $signed({2'b00, adx_q});
        end
        x_step   = sx_neg_q ? (x_q - XI_W'(1)) : (x_q + XI_W'(1));
        y_step   = sy_neg_q ? (y_q - YI_W'(1)) : (y_q + YI_W'(1));
`ifdef LINE_RASTER_CLIP_EN
        offscreen = x_q[XI_W-1] || (x_q >= C_SCR_W) ||
                    y_q[YI_W-1] || (y_q >= C_SCR_H);
`else
        offscreen = 1'b0;
`endif
        out_free = !pix_valid_q || pix_ready;
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        color_d     = color_q;
        adx_d       = adx_q;
        ady_d       = ady_q;
        sx_neg_d    = sx_neg_q;
        sy_neg_d    = sy_neg_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        pix_valid_d = pix_valid_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    x_d     = {2'b00, cmd_x0};
                    y_d     = {2'b00, cmd_y0};
                    dx_d    = cmd_dx;
                    dy_d    = cmd_dy;
                    color_d = cmd_color;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                adx_d    = abs_dx;
                ady_d    = abs_dy;
                sx_neg_d = dx_q[LEN_W-1];
                sy_neg_d = dy_q[LEN_W-1];
                err_d    = $signed({2'b00, abs_dx}) - $signed({2'b00, abs_dy});
                cnt_d    = ((abs_dx > abs_dy) ? abs_dx : abs_dy) + CNT_W'(1);
                state_d  = S_DRAW;
            end
            S_DRAW: begin
                if (pix_valid_q && pix_ready) begin
                    pix_valid_d = 1'b0;
                end
                // Iterator feeds the output register; clipped pixels bypass it
                if ((cnt_q != '0) && (offscreen || out_free)) begin
                    if (!offscreen) begin
                        pix_valid_d = 1'b1;
                        pix_x_d     = x_q[X_W-1:0];
                        pix_y_d     = y_q[Y_W-1:0];
                    end
                    if (step_x) begin
                        x_d = x_step;
                    end
                    if (step_y) begin
                        y_d = y_step;
                    end
                    err_d = err_step;
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if ((cnt_d == '0) && !pix_valid_d) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            color_q     <= '0;
            adx_q       <= '0;
            ady_q       <= '0;
            sx_neg_q    <= 1'b0;
            sy_neg_q    <= 1'b0;
            err_q       <= '0;
            cnt_q       <= '0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            color_q     <= color_d;
            adx_q       <= adx_d;
            ady_q       <= ady_d;
            sx_neg_q    <= sx_neg_d;
            sy_neg_q    <= sy_neg_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_color = color_q;

endmodule
`default_nettype wire

// File: tb/tb_line_raster.sv
`default_nettype none
// =============================================================================
// Module   : tb_line_raster
// Purpose  : Directed vector table plus reset corner case for line_raster.
// Revision : 1.0 - initial release
// =============================================================================
module tb_line_raster;

    localparam int BUDGET = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_x0 = '0;
    logic [6:0] cmd_y0 = '0;
    logic [7:0] cmd_dx = '0;
    logic [7:0] cmd_dy = '0;
    logic [2:0] cmd_color = '0;
    logic       pix_valid;
    logic       pix_ready = 1'b0;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_color;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string name;
        int    x0, y0, dx, dy, col;
        bit    rnd;
        bit    chk_t;
        int    n, lx, ly;
    } vec_t;

    line_raster dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_dx    (cmd_dx),
        .cmd_dy    (cmd_dy),
        .cmd_color (cmd_color),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input int x0, input int y0, input int dx,
                                input int dy, input int col, input bit rnd, input bit ct,
                                input int n, input int lx, input int ly);
        vec_t v;
        v.name = nm; v.x0 = x0; v.y0 = y0; v.dx = dx; v.dy = dy; v.col = col;
        v.rnd = rnd; v.chk_t = ct; v.n = n; v.lx = lx; v.ly = ly;
        return v;
    endfunction

    function automatic logic [31:0] pk_out();
        return {14'b0, pix_x, pix_y, pix_color};
    endfunction

    task automatic run_line(input vec_t v);
        int mx[$];
        int my[$];
        int adx, ady, sx, sy, err, e2, n, x, y;
        int c, idx, first_c, last_c, done_c, busy_n, done_n, exp_pk;
        bit stalled, rdy, rdy_ok;
        logic [31:0] held, last_pk;

        // reference Bresenham walk
        adx = (v.dx < 0) ? -v.dx : v.dx;
        ady = (v.dy < 0) ? -v.dy : v.dy;
        sx  = (v.dx < 0) ? -1 : 1;
        sy  = (v.dy < 0) ? -1 : 1;
        err = adx - ady;
        n   = ((adx > ady) ? adx : ady) + 1;
        x   = v.x0;
        y   = v.y0;
        for (int i = 0; i < n; i++) begin
`ifdef LINE_RASTER_CLIP_EN
            if (x >= 0 && x < 160 && y >= 0 && y < 120) begin
                mx.push_back(x);
                my.push_back(y);
            end
`else
            mx.push_back(x & 255);
            my.push_back(y & 127);
`endif
            e2 = 2 * err;
            if (e2 > -ady) begin err -= ady; x += sx; end
            if (e2 < adx)  begin err += adx; y += sy; end
        end

        @(negedge clk);
        chk({v.name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_x0    = 8'(v.x0);
        cmd_y0    = 7'(v.y0);
        cmd_dx    = 8'(v.dx);
        cmd_dy    = 8'(v.dy);
        cmd_color = 3'(v.col);
        @(negedge clk);
        cmd_valid = 1'b0;

        c = 0; idx = 0; first_c = -1; last_c = -1; done_c = -1;
        busy_n = 0; done_n = 0; stalled = 1'b0; rdy_ok = 1'b1;
        held = '0; last_pk = '0;
        while (c < BUDGET && (done_c < 0 || c <= done_c + 2)) begin
            if (busy) busy_n++;
            if (cmd_ready == busy) rdy_ok = 1'b0;
            if (done) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            if (stalled) begin
                chk({v.name, "_stall_valid"}, 32'(pix_valid), 32'd1);
                chk({v.name, "_stall_hold"}, pk_out(), held);
            end
            if (pix_valid && first_c < 0) first_c = c;
            rdy = v.rnd ? 1'($urandom & 1) : 1'b1;
            pix_ready = rdy;
            if (pix_valid && rdy) begin
                if (idx < mx.size()) begin
                    exp_pk = (mx[idx] << 10) | (my[idx] << 3) | v.col;
                    chk({v.name, "_pixel"}, pk_out(), 32'(exp_pk));
                end
                last_pk = pk_out();
                last_c  = c;
                idx++;
            end
            stalled = pix_valid && !rdy;
            held    = pk_out();
            @(negedge clk);
            c++;
        end
        pix_ready = 1'b1;

        chk({v.name, "_count"}, 32'(idx), 32'(v.n));
        chk({v.name, "_done_pulses"}, 32'(done_n), 32'd1);
        chk({v.name, "_busy_cycles"}, 32'(busy_n), 32'(done_c));
        chk({v.name, "_ready_vs_busy"}, 32'(rdy_ok), 32'd1);
        if (v.n > 0) begin
            chk({v.name, "_last_pixel"}, last_pk, 32'((v.lx << 10) | (v.ly << 3) | v.col));
        end
        if (v.chk_t) begin
            chk({v.name, "_first_latency"}, 32'(first_c), 32'd2);
            chk({v.name, "_back_to_back"}, 32'(last_c - first_c), 32'(v.n - 1));
            chk({v.name, "_done_timing"}, 32'(done_c), 32'(last_c + 1));
        end
    endtask

    initial begin
        vec_t tbl[9];
        bit   saw_done;

        tbl[0] = mk("horiz",     50,   0,   10,   0, 5, 1'b0, 1'b1, 11,  60,  0);
        tbl[1] = mk("vert_neg",  59,  49,    0, -10, 2, 1'b0, 1'b1, 11,  59, 39);
        tbl[2] = mk("diag_long",  0,   0,   60,  50, 7, 1'b0, 1'b1, 61,  60, 50);
        tbl[3] = mk("backpress",  0,   0,    3,   3, 3, 1'b1, 1'b0,  4,   3,  3);
        tbl[4] = mk("single",     0,   0,    0,   0, 1, 1'b0, 1'b1,  1,   0,  0);
        tbl[5] = mk("steep_neg", 100, 100,  -3,  -7, 6, 1'b0, 1'b1,  8,  97, 93);
`ifdef LINE_RASTER_CLIP_EN
        tbl[6] = mk("min_dx",   200,   5, -128,   0, 4, 1'b0, 1'b0, 88,  72,  5);
        tbl[7] = mk("edge",     150, 110,   20,  20, 5, 1'b0, 1'b0, 10, 159, 119);
        tbl[8] = mk("offscreen", 200, 10,    5,   0, 3, 1'b0, 1'b0,  0,   0,  0);
`else
        tbl[6] = mk("min_dx",   200,   5, -128,   0, 4, 1'b0, 1'b1, 129, 72,  5);
        tbl[7] = mk("edge",     150, 110,   20,  20, 5, 1'b0, 1'b1, 21, 170,  2);
        tbl[8] = mk("offscreen", 200, 10,    5,   0, 3, 1'b0, 1'b1,  6, 205, 10);
`endif

        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_pix_valid", 32'(pix_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_pixel", pk_out(), 32'd0);
        rst = 1'b0;
        pix_ready = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_line(tbl[i]);
        end

        // reset in the middle of a long line
        @(negedge clk);
        cmd_valid = 1'b1; cmd_x0 = 8'd0; cmd_y0 = 7'd0;
        cmd_dx = 8'd60; cmd_dy = 8'd50; cmd_color = 3'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_mid_valid_before", 32'(pix_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_async_done", 32'(done), 32'd0);
        chk("rst_async_pixel", pk_out(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("rst_no_done", 32'(saw_done), 32'd0);
        run_line(mk("after_rst", 10, 20, 4, -2, 2, 1'b0, 1'b1, 5, 14, 18));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
